clint_timer_swi: RTL and testbench
==================================

Name: clint_timer_swi

Overview:
- Core-local timer and software-interrupt unit.
- Sits directly upstream of the interrupt CSR block and drives its MTimerInt and MSwInt inputs.
- Holds a free-running 64-bit mtime, a 64-bit mtimecmp and a 1-bit msip, all reachable through a 32-bit request/response register port.
- Produces a registered machine-timer interrupt and a machine software interrupt.

Parameters:
- TIMEDIV, default 1: mtime increments once every TIMEDIV clk cycles; legal range 1..65535.
- ADRW, default 16: register-port byte-address width.

Ports:
- clk  in  1  core clock
- resetn  in  1  synchronous active-low reset
- ReqValid  in  1  register request valid
- ReqReady  out  1  request accepted when ReqValid & ReqReady
- ReqWrite  in  1  1 = write, 0 = read
- ReqAdr  in  ADRW  byte address; bits [1:0] ignored
- ReqWData  in  32  write data
- ReqStrb  in  4  byte write strobes
- RspValid  out  1  response valid
- RspReady  in  1  response consumed when RspValid & RspReady
- RspRData  out  32  read data; 0 for writes
- RspErr  out  1  unmapped address
- MTimerInt  out  1  mtime >= mtimecmp (registered)
- MSwInt  out  1  msip[0]
- MTime  out  64  current mtime, for a time CSR shadow

Behaviour:
- Reset (resetn=0 at posedge clk):
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescale counter=0.
  - RspValid=0, RspRData=0, RspErr=0, MTimerInt=0, MSwInt=0.
  - Reset mid-transaction drops any pending response; the request is lost.
- Register map (word address ReqAdr[ADRW-1:2]):
  - 0x0000: msip. Bit 0 only; other bits read 0 and writes to them are ignored.
  - 0x4000: mtimecmp[31:0]
  - 0x4004: mtimecmp[63:32]
  - 0xBFF8: mtime[31:0]
  - 0xBFFC: mtime[63:32]
  - Any other address: read returns 0; write is ignored; RspErr=1.
- Handshake:
  - ReqReady = ~RspValid | RspReady (combinational).
  - An accepted request produces RspValid on the next cycle.
  - RspValid, RspRData and RspErr hold stable until RspReady.
  - Back-to-back requests sustain one per cycle while RspReady=1.
- Read data is sampled at the accept cycle, i.e. the pre-update value for that clk edge.
- Writes apply per byte under ReqStrb at the accept edge.
- Prescaler:
  - Counter runs 0..TIMEDIV-1 and wraps.
  - Tick = (counter == TIMEDIV-1).
  - TIMEDIV=1 gives a tick every cycle.
- mtime update:
  - On tick, mtime <= mtime + 1 with full 64-bit carry; wraps from all-ones to 0.
  - A register write to either mtime half in the same cycle as a tick takes priority over the increment for the whole 64-bit register.
  - The written half takes the new bytes; the other half keeps its old value with no increment that cycle.
  - A write does not reset the prescaler.
- MTimerInt is registered: MTimerInt <= (mtime >= mtimecmp), unsigned, evaluated on the current register values. It lags any change to mtime or mtimecmp by exactly one cycle.
- MSwInt = msip[0] directly from its flop, so it is valid the cycle after the write.
- MTime = mtime register output.

Test Plan:
- Reset: hold resetn=0 for 3 cycles, then release -> read 0xBFF8=0, 0x4000=FFFF_FFFF, 0x0000=0; MTimerInt=0, MSwInt=0.
- Prescaler: TIMEDIV=4, free-run 40 cycles after reset -> read 0xBFF8 returns 10 (±1 per the documented sample point); MTime increments exactly every 4th cycle.
- Compare: write mtimecmp hi=0, then lo=20 with TIMEDIV=1 -> MTimerInt rises exactly one cycle after mtime==20. Then write lo=FFFF_FFFF -> MTimerInt falls one cycle later.
- Carry and collision:
  - Write mtime lo=FFFF_FFFF, hi=0 -> next tick gives hi=1, lo=0.
  - Write lo=5 coincident with a tick -> mtime lo=5 and hi unchanged that cycle.
- msip and strobes: write 0x0000 data=FFFF_FFFF strb=1111 -> MSwInt=1 next cycle and read returns 1. Write strb=0000 -> no change.
- Backpressure and error:
  - Hold RspReady=0 after a read -> ReqReady=0 and RspRData stable for 5 cycles.
  - Access 0x1234 -> RspErr=1, RspRData=0, no register changes.

Source files
------------

// File: rtl/clint_timer_swi.sv
`timescale 1ns/1ps
// Core-local timer (64-bit mtime/mtimecmp) and software interrupt (msip),
// accessed through a 32-bit valid/ready register port with one-cycle response.
module clint_timer_swi #(
    parameter int unsigned TIMEDIV = 1,
    parameter int unsigned ADRW    = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            ReqValid,
    output logic            ReqReady,
    input  logic            ReqWrite,
    input  logic [ADRW-1:0] ReqAdr,
    input  logic [31:0]     ReqWData,
    input  logic [3:0]      ReqStrb,
    output logic            RspValid,
    input  logic            RspReady,
    output logic [31:0]     RspRData,
    output logic            RspErr,
    output logic            MTimerInt,
    output logic            MSwInt,
    output logic [63:0]     MTime
);

    localparam logic [ADRW-1:0] A_MSIP    = ADRW'(32'h0000);
    localparam logic [ADRW-1:0] A_CMP_LO  = ADRW'(32'h4000);
    localparam logic [ADRW-1:0] A_CMP_HI  = ADRW'(32'h4004);
    localparam logic [ADRW-1:0] A_TIME_LO = ADRW'(32'hBFF8);
    localparam logic [ADRW-1:0] A_TIME_HI = ADRW'(32'hBFFC);
    localparam logic [15:0]     DIV_LAST  = 16'(TIMEDIV - 1);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;
    logic [15:0] presc;
    logic        tick;
    logic        accept;
    logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi, hit;
    logic        wr_msip, wr_cmp_lo, wr_cmp_hi, wr_time_lo, wr_time_hi;
    logic [31:0] rd_data;
    logic        adr_unused;

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return r;
    endfunction

    assign adr_unused  = &{1'b1, ReqAdr[1:0]};
    assign ReqReady    = ~RspValid | RspReady;
    assign accept      = ReqValid & ReqReady;
    assign tick        = (presc == DIV_LAST);

    assign sel_msip    = (ReqAdr[ADRW-1:2] == A_MSIP[ADRW-1:2]);
    assign sel_cmp_lo  = (ReqAdr[ADRW-1:2] == A_CMP_LO[ADRW-1:2]);
    assign sel_cmp_hi  = (ReqAdr[ADRW-1:2] == A_CMP_HI[ADRW-1:2]);
    assign sel_time_lo = (ReqAdr[ADRW-1:2] == A_TIME_LO[ADRW-1:2]);
    assign sel_time_hi = (ReqAdr[ADRW-1:2] == A_TIME_HI[ADRW-1:2]);
    assign hit         = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_time_lo | sel_time_hi;

    assign wr_msip     = accept & ReqWrite & sel_msip;
    assign wr_cmp_lo   = accept & ReqWrite & sel_cmp_lo;
    assign wr_cmp_hi   = accept & ReqWrite & sel_cmp_hi;
    assign wr_time_lo  = accept & ReqWrite & sel_time_lo;
    assign wr_time_hi  = accept & ReqWrite & sel_time_hi;

    always_comb begin
        rd_data = '0;
        if (sel_msip)
            rd_data = {31'd0, msip};
        else if (sel_cmp_lo)
            rd_data = mtimecmp[31:0];
        else if (sel_cmp_hi)
            rd_data = mtimecmp[63:32];
        else if (sel_time_lo)
            rd_data = mtime[31:0];
        else if (sel_time_hi)
            rd_data = mtime[63:32];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            msip      <= 1'b0;
            presc     <= '0;
            MTimerInt <= 1'b0;
            RspValid  <= 1'b0;
            RspRData  <= '0;
            RspErr    <= 1'b0;
        end else begin
            presc <= tick ? 16'd0 : presc + 16'd1;

            // A write to either half wins over the tick for the whole register.
            if (wr_time_lo)
                mtime <= {mtime[63:32], merge(mtime[31:0], ReqWData, ReqStrb)};
            else if (wr_time_hi)
                mtime <= {merge(mtime[63:32], ReqWData, ReqStrb), mtime[31:0]};
            else if (tick)
                mtime <= mtime + 64'd1;

            if (wr_cmp_lo)
                mtimecmp[31:0] <= merge(mtimecmp[31:0], ReqWData, ReqStrb);
            if (wr_cmp_hi)
                mtimecmp[63:32] <= merge(mtimecmp[63:32], ReqWData, ReqStrb);
            if (wr_msip && ReqStrb[0])
                msip <= ReqWData[0];

            MTimerInt <= (mtime >= mtimecmp);

            if (accept) begin
                RspValid <= 1'b1;
                RspRData <= ReqWrite ? 32'd0 : rd_data;
                RspErr   <= ~hit;
            end else if (RspReady) begin
                RspValid <= 1'b0;
            end
        end
    end

    assign MSwInt = msip;
    assign MTime  = mtime;

endmodule

// File: tb/tb_clint_timer_swi.sv
`timescale 1ns/1ps
// Bench for clint_timer_swi: a reference model queues expected responses at
// accept time; test tasks pop and compare them against captured responses.
module tb_clint_timer_swi;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ReqValid, ReqWrite, RspReady;
    logic [15:0] ReqAdr;
    logic [31:0] ReqWData;
    logic [3:0]  ReqStrb;
    logic        ReqReady, RspValid, RspErr, MTimerInt, MSwInt;
    logic [31:0] RspRData;
    logic [63:0] MTime;

    logic        resetn4;
    logic [63:0] MTime4;
    logic        unused4_rr, unused4_rv, unused4_err, unused4_mti, unused4_msi;
    logic [31:0] unused4_rd;

    int n_cmp = 0;
    int n_err = 0;

    logic [32:0] exp_q[$];
    logic [32:0] act_q[$];
    logic [32:0] e, a;

    logic [63:0] m_mtime, m_cmp, m_nt;
    logic        m_msip, m_mti, m_nmti, m_rv, m_acc, m_er;
    logic [31:0] m_rd;

    always #5 clk = ~clk;

    clint_timer_swi #(.TIMEDIV(1), .ADRW(16)) dut (
        .clk(clk), .resetn(resetn), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqWrite(ReqWrite), .ReqAdr(ReqAdr), .ReqWData(ReqWData), .ReqStrb(ReqStrb),
        .RspValid(RspValid), .RspReady(RspReady), .RspRData(RspRData), .RspErr(RspErr),
        .MTimerInt(MTimerInt), .MSwInt(MSwInt), .MTime(MTime)
    );

    clint_timer_swi #(.TIMEDIV(4), .ADRW(16)) dut4 (
        .clk(clk), .resetn(resetn4), .ReqValid(1'b0), .ReqReady(unused4_rr),
        .ReqWrite(1'b0), .ReqAdr(16'h0), .ReqWData(32'h0), .ReqStrb(4'h0),
        .RspValid(unused4_rv), .RspReady(1'b1), .RspRData(unused4_rd), .RspErr(unused4_err),
        .MTimerInt(unused4_mti), .MSwInt(unused4_msi), .MTime(MTime4)
    );

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[b*8 +: 8] = s[b] ? n[b*8 +: 8] : o[b*8 +: 8];
        return r;
    endfunction

    // Reference model of the TIMEDIV=1 instance.
    always @(posedge clk) begin
        if (!resetn) begin
            m_mtime = 64'd0; m_cmp = '1; m_msip = 1'b0; m_mti = 1'b0; m_rv = 1'b0;
            exp_q.delete();
        end else begin
            m_acc  = ReqValid && (!m_rv || RspReady);
            m_nmti = (m_mtime >= m_cmp);
            if (m_rv && RspReady) m_rv = 1'b0;
            m_nt = m_mtime + 64'd1;
            if (m_acc) begin
                m_rv = 1'b1;
                m_er = 1'b0;
                case (ReqAdr & 16'hFFFC)
                    16'h0000: m_rd = {31'd0, m_msip};
                    16'h4000: m_rd = m_cmp[31:0];
                    16'h4004: m_rd = m_cmp[63:32];
                    16'hBFF8: m_rd = m_mtime[31:0];
                    16'hBFFC: m_rd = m_mtime[63:32];
                    default: begin m_rd = 32'd0; m_er = 1'b1; end
                endcase
                exp_q.push_back({ReqWrite ? 32'd0 : m_rd, m_er});
                if (ReqWrite) begin
                    case (ReqAdr & 16'hFFFC)
                        16'h0000: if (ReqStrb[0]) m_msip = ReqWData[0];
                        16'h4000: m_cmp[31:0]  = bmerge(m_cmp[31:0], ReqWData, ReqStrb);
                        16'h4004: m_cmp[63:32] = bmerge(m_cmp[63:32], ReqWData, ReqStrb);
                        16'hBFF8: m_nt = {m_mtime[63:32], bmerge(m_mtime[31:0], ReqWData, ReqStrb)};
                        16'hBFFC: m_nt = {bmerge(m_mtime[63:32], ReqWData, ReqStrb), m_mtime[31:0]};
                        default: ;
                    endcase
                end
            end
            m_mtime = m_nt;
            m_mti   = m_nmti;
        end
    end

    always @(negedge clk)
        if (resetn && RspValid && RspReady)
            act_q.push_back({RspRData, RspErr});

    task automatic drive(input logic wr, input logic [15:0] adr, input logic [31:0] d,
                         input logic [3:0] s);
        ReqValid = 1'b1; ReqWrite = wr; ReqAdr = adr; ReqWData = d; ReqStrb = s;
        @(posedge clk); #1;
        ReqValid = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (MTime !== 64'd0) begin n_err++; $display("FAIL reset_mtime: got %h want 0", MTime); end
        n_cmp++; if (MTimerInt !== 1'b0) begin n_err++; $display("FAIL reset_mti: got %b want 0", MTimerInt); end
        n_cmp++; if (MSwInt !== 1'b0) begin n_err++; $display("FAIL reset_msi: got %b want 0", MSwInt); end
        n_cmp++; if (RspValid !== 1'b0) begin n_err++; $display("FAIL reset_rspvalid: got %b want 0", RspValid); end
        resetn = 1'b1;
        drive(1'b0, 16'hBFF8, 32'h0, 4'h0);
        drive(1'b0, 16'h4000, 32'h0, 4'h0);
        drive(1'b0, 16'h0000, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            n_cmp++;
            if (act_q.size() == 0) begin
                n_err++; e = exp_q.pop_front();
                $display("FAIL reset_rsp: missing response, want rdata %h err %b", e[32:1], e[0]);
            end else begin
                e = exp_q.pop_front(); a = act_q.pop_front();
                if (a !== e) begin n_err++;
                    $display("FAIL reset_rsp: got rdata %h err %b want rdata %h err %b", a[32:1], a[0], e[32:1], e[0]); end
            end
        end
        n_cmp++; if (act_q.size() != 0) begin n_err++; $display("FAIL reset_extra: %0d unexpected responses, want 0", act_q.size()); act_q.delete(); end
    endtask

    task automatic test_prescaler;
        resetn4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn4 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (MTime4 !== 64'(k / 4)) begin n_err++;
                $display("FAIL prescale_cyc%0d: got %0d want %0d", k, MTime4, k / 4); end
        end
    endtask

    task automatic test_compare;
        logic found;
        drive(1'b1, 16'hBFFC, 32'h0, 4'hF);
        drive(1'b1, 16'hBFF8, 32'h0, 4'hF);
        drive(1'b1, 16'h4004, 32'h0, 4'hF);
        drive(1'b1, 16'h4000, 32'd20, 4'hF);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #1;
            if (MTime == 64'd20) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL cmp_wait: mtime never reached 20, got %0d", MTime); end
        else begin
            n_cmp++; if (MTimerInt !== 1'b0) begin n_err++; $display("FAIL cmp_at20: got %b want 0", MTimerInt); end
            @(posedge clk); #1;
            n_cmp++; if (MTimerInt !== 1'b1) begin n_err++; $display("FAIL cmp_rise: got %b want 1", MTimerInt); end
        end
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAdr = 16'h4000; ReqWData = 32'hFFFF_FFFF; ReqStrb = 4'hF;
        @(posedge clk); #1;
        ReqValid = 1'b0;
        n_cmp++; if (MTimerInt !== 1'b1) begin n_err++; $display("FAIL cmp_hold: got %b want 1", MTimerInt); end
        @(posedge clk); #1;
        n_cmp++; if (MTimerInt !== 1'b0) begin n_err++; $display("FAIL cmp_fall: got %b want 0", MTimerInt); end
        repeat (2) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            n_cmp++;
            if (act_q.size() == 0) begin
                n_err++; e = exp_q.pop_front();
                $display("FAIL cmp_rsp: missing response, want rdata %h err %b", e[32:1], e[0]);
            end else begin
                e = exp_q.pop_front(); a = act_q.pop_front();
                if (a !== e) begin n_err++;
                    $display("FAIL cmp_rsp: got rdata %h err %b want rdata %h err %b", a[32:1], a[0], e[32:1], e[0]); end
            end
        end
    endtask

    task automatic test_carry;
        drive(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        drive(1'b1, 16'hBFFC, 32'h0, 4'hF);
        n_cmp++; if (MTime !== 64'h0000_0000_FFFF_FFFF) begin n_err++; $display("FAIL carry_pre: got %h want 00000000ffffffff", MTime); end
        @(posedge clk); #1;
        n_cmp++; if (MTime !== 64'h0000_0001_0000_0000) begin n_err++; $display("FAIL carry_tick: got %h want 0000000100000000", MTime); end
        drive(1'b1, 16'hBFF8, 32'd5, 4'hF);
        n_cmp++; if (MTime !== 64'h0000_0001_0000_0005) begin n_err++; $display("FAIL collide: got %h want 0000000100000005", MTime); end
        @(posedge clk); #1;
        n_cmp++; if (MTime !== 64'h0000_0001_0000_0006) begin n_err++; $display("FAIL collide_next: got %h want 0000000100000006", MTime); end
        drive(1'b1, 16'hBFFC, 32'hAABB_CCDD, 4'b0101);
        n_cmp++; if (MTime !== 64'h00BB_00DD_0000_0006) begin n_err++; $display("FAIL strb_hi: got %h want 00bb00dd00000006", MTime); end
        drive(1'b0, 16'hBFFC, 32'h0, 4'h0);
        drive(1'b0, 16'hBFF8, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            n_cmp++;
            if (act_q.size() == 0) begin
                n_err++; e = exp_q.pop_front();
                $display("FAIL carry_rsp: missing response, want rdata %h err %b", e[32:1], e[0]);
            end else begin
                e = exp_q.pop_front(); a = act_q.pop_front();
                if (a !== e) begin n_err++;
                    $display("FAIL carry_rsp: got rdata %h err %b want rdata %h err %b", a[32:1], a[0], e[32:1], e[0]); end
            end
        end
    endtask

    task automatic test_msip;
        n_cmp++; if (MSwInt !== 1'b0) begin n_err++; $display("FAIL msip_init: got %b want 0", MSwInt); end
        drive(1'b1, 16'h0000, 32'hFFFF_FFFF, 4'hF);
        n_cmp++; if (MSwInt !== 1'b1) begin n_err++; $display("FAIL msip_set: got %b want 1", MSwInt); end
        drive(1'b0, 16'h0000, 32'h0, 4'h0);
        drive(1'b1, 16'h0000, 32'h0, 4'h0);
        n_cmp++; if (MSwInt !== 1'b1) begin n_err++; $display("FAIL msip_nostrb: got %b want 1", MSwInt); end
        drive(1'b1, 16'h0000, 32'hFFFF_FFFE, 4'h1);
        n_cmp++; if (MSwInt !== 1'b0) begin n_err++; $display("FAIL msip_clr: got %b want 0", MSwInt); end
        drive(1'b0, 16'h0002, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            n_cmp++;
            if (act_q.size() == 0) begin
                n_err++; e = exp_q.pop_front();
                $display("FAIL msip_rsp: missing response, want rdata %h err %b", e[32:1], e[0]);
            end else begin
                e = exp_q.pop_front(); a = act_q.pop_front();
                if (a !== e) begin n_err++;
                    $display("FAIL msip_rsp: got rdata %h err %b want rdata %h err %b", a[32:1], a[0], e[32:1], e[0]); end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] adrs [5];
        logic        wrs  [5];
        adrs = '{16'hBFF8, 16'h4000, 16'h4000, 16'hBFFC, 16'h4004};
        wrs  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            ReqValid = 1'b1; ReqWrite = wrs[i]; ReqAdr = adrs[i];
            ReqWData = 32'h1234_5678; ReqStrb = 4'hF;
            n_cmp++; if (ReqReady !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d: got %b want 1", i, ReqReady); end
            @(posedge clk); #1;
            n_cmp++; if (RspValid !== 1'b1) begin n_err++; $display("FAIL b2b_valid%0d: got %b want 1", i, RspValid); end
        end
        ReqValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            n_cmp++;
            if (act_q.size() == 0) begin
                n_err++; e = exp_q.pop_front();
                $display("FAIL b2b_rsp: missing response, want rdata %h err %b", e[32:1], e[0]);
            end else begin
                e = exp_q.pop_front(); a = act_q.pop_front();
                if (a !== e) begin n_err++;
                    $display("FAIL b2b_rsp: got rdata %h err %b want rdata %h err %b", a[32:1], a[0], e[32:1], e[0]); end
            end
        end
    endtask

    task automatic test_backpressure_err;
        RspReady = 1'b0;
        drive(1'b0, 16'h4004, 32'h0, 4'h0);
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAdr = 16'h1234; ReqWData = 32'hDEAD_BEEF; ReqStrb = 4'hF;
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (ReqReady !== 1'b0) begin n_err++; $display("FAIL bp_ready%0d: got %b want 0", k, ReqReady); end
            n_cmp++; if (RspValid !== 1'b1) begin n_err++; $display("FAIL bp_valid%0d: got %b want 1", k, RspValid); end
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL bp_data%0d: no expected entry, got %h", k, RspRData); end
            else if (RspRData !== exp_q[0][32:1]) begin n_err++;
                $display("FAIL bp_data%0d: got %h want %h", k, RspRData, exp_q[0][32:1]); end
            @(posedge clk); #1;
        end
        RspReady = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 16'h1234, 32'h0, 4'h0);
        drive(1'b0, 16'h4000, 32'h0, 4'h0);
        drive(1'b0, 16'h4004, 32'h0, 4'h0);
        drive(1'b0, 16'h0000, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            n_cmp++;
            if (act_q.size() == 0) begin
                n_err++; e = exp_q.pop_front();
                $display("FAIL bp_rsp: missing response, want rdata %h err %b", e[32:1], e[0]);
            end else begin
                e = exp_q.pop_front(); a = act_q.pop_front();
                if (a !== e) begin n_err++;
                    $display("FAIL bp_rsp: got rdata %h err %b want rdata %h err %b", a[32:1], a[0], e[32:1], e[0]); end
            end
        end
    endtask

    task automatic test_reset_mid;
        RspReady = 1'b0;
        drive(1'b0, 16'hBFF8, 32'h0, 4'h0);
        n_cmp++; if (RspValid !== 1'b1) begin n_err++; $display("FAIL mid_pending: got %b want 1", RspValid); end
        resetn = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (RspValid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", RspValid); end
        n_cmp++; if (RspRData !== 32'd0) begin n_err++; $display("FAIL mid_rdata: got %h want 0", RspRData); end
        n_cmp++; if (MTime !== 64'd0) begin n_err++; $display("FAIL mid_mtime: got %h want 0", MTime); end
        resetn = 1'b1;
        RspReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (act_q.size() != 0) begin n_err++; $display("FAIL mid_lost: got %0d responses want 0", act_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; resetn4 = 1'b0;
        ReqValid = 1'b0; ReqWrite = 1'b0; ReqAdr = 16'h0; ReqWData = 32'h0; ReqStrb = 4'h0;
        RspReady = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_prescaler();
        test_compare();
        test_carry();
        test_msip();
        test_back_to_back();
        test_backpressure_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
